// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit MIPS-style core.
// Optional MULTICYCLE_STATS_EN adds saturating instruction and busy-cycle counters.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] state_out,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       halted,
  output logic       fault
`ifdef MULTICYCLE_STATS_EN
  ,
  output logic [15:0] instr_count,
  output logic [15:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t           state, state_next;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] wait_cnt, wait_next;
  logic             timeout;

  // Holds at all-ones so a disabled watchdog never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc_wait(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign timeout   = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign state_out = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      op_q     <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = '0;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src    = 1'b0;
    alu_op     = 2'd0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      S_IDLE: if (run) state_next = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
        end else begin
          wait_next = sat_inc_wait(wait_cnt);
        end
      end
      S_DECODE: begin
        // Decode uses the live IR field; the latch only feeds later states.
        case (opcode)
          OP_HALT: state_next = S_HALT;
          OP_J: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            state_next = S_FETCH;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:  state_next = S_WB;
          OP_SUB: begin
            alu_op     = 2'd1;
            state_next = S_WB;
          end
          OP_ADDI: begin
            alu_src    = 1'b1;
            state_next = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src    = 1'b1;
            state_next = S_MEM;
          end
          OP_BEQ: begin
            alu_op     = 2'd1;
            pc_src     = 2'd1;
            pc_write   = zero;
            state_next = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q != OP_LW);
        if (mem_ready) begin
          state_next = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_next = S_FAULT;
        end else begin
          wait_next = sat_inc_wait(wait_cnt);
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        state_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef MULTICYCLE_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (state == S_FETCH && mem_ready) instr_count <= sat_inc16(instr_count);
      if (!(state inside {S_IDLE, S_HALT, S_FAULT})) cycle_count <= sat_inc16(cycle_count);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: builds per-instruction expected cycle sequences from the
// opcode semantics and memory wait draws, then replays them against the DUT.
module tb_multicycle_control_fsm;

  localparam int TMO = 15;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_FAULT = 3'd7;
  localparam logic [2:0] I_SUB = 3'd1, I_ADDI = 3'd2, I_LW = 3'd3, I_SW = 3'd4,
                         I_BEQ = 3'd5, I_J = 3'd6, I_HALT = 3'd7;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg, reg_write, halted, fault;
  } outs_t;

  typedef struct packed {
    logic       run;
    logic [2:0] op;
    logic       zero;
    logic       rdy;
    outs_t      exp;
  } step_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state_out;
  logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       mem_to_reg, reg_write, halted, fault;
`ifdef MULTICYCLE_STATS_EN
  logic [15:0] instr_count, cycle_count;
`endif

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .state_out(state_out), .mem_req(mem_req), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .halted(halted), .fault(fault)
`ifdef MULTICYCLE_STATS_EN
    , .instr_count(instr_count), .cycle_count(cycle_count)
`endif
  );

  always #5 clock = ~clock;

  outs_t got;
  assign got = {state_out, mem_req, mem_read, mem_write, iord, ir_write, pc_write,
                pc_src, alu_src, alu_op, mem_to_reg, reg_write, halted, fault};

  step_t q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    force_wait = -1;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] r3();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic push(input outs_t o, input logic r, input logic [2:0] op,
                      input logic z, input logic rdy);
    step_t s;
    s.run = r; s.op = op; s.zero = z; s.rdy = rdy; s.exp = o;
    q.push_back(s);
  endtask

  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) push(blank(ST_IDLE), 1'b0, r3(), rb(), rb());
    push(blank(ST_IDLE), 1'b1, r3(), rb(), rb());
  endtask

  // Wait-cycle draw for one memory access; TMO+1 means memory never answers.
  function automatic int pick_wait();
    int r;
    if (force_wait >= 0) begin
      r = force_wait;
      force_wait = -1;
      return r;
    end
    r = $urandom_range(0, 39);
    if (r < 24) return 0;
    if (r < 36) return $urandom_range(1, 3);
    if (r == 36) return TMO;
    if (r == 37) return TMO + 1;
    return $urandom_range(4, 8);
  endfunction

  task automatic push_access(input outs_t waiting, input outs_t done, output bit faulted);
    int    w;
    outs_t f;
    w = pick_wait();
    faulted = 1'b0;
    if (w > TMO) begin
      // The watchdog trips once TMO wait cycles have elapsed and memory is still silent.
      for (int i = 0; i <= TMO; i++) push(waiting, rb(), r3(), rb(), 1'b0);
      f = blank(ST_FAULT);
      f.fault = 1'b1;
      for (int i = 0; i < 3; i++) push(f, rb(), r3(), rb(), rb());
      faulted = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(waiting, rb(), r3(), rb(), 1'b0);
      push(done, rb(), r3(), rb(), 1'b1);
    end
  endtask

  task automatic gen_episode();
    outs_t      o, d;
    bit         flt;
    logic [2:0] op;
    logic       z, r;
    int         n;
    q.delete();
    push_idle($urandom_range(0, 2));
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      op = r3();
      o = blank(ST_FETCH);
      o.mem_req = 1'b1; o.mem_read = 1'b1;
      d = o;
      d.ir_write = 1'b1; d.pc_write = 1'b1;
      push_access(o, d, flt);
      if (flt) return;
      o = blank(ST_DECODE);
      if (op == I_J) begin
        o.pc_write = 1'b1; o.pc_src = 2'd2;
      end
      push(o, rb(), op, rb(), rb());
      if (op == I_HALT) begin
        o = blank(ST_HALT);
        o.halted = 1'b1;
        for (int k = 0; k < 3; k++) push(o, rb(), r3(), rb(), rb());
        return;
      end
      if (op == I_J) continue;
      o = blank(ST_EXEC);
      z = rb();
      case (op)
        I_SUB: o.alu_op = 2'd1;
        I_ADDI, I_LW, I_SW: o.alu_src = 1'b1;
        I_BEQ: begin
          o.alu_op = 2'd1; o.pc_src = 2'd1; o.pc_write = z;
        end
        default: ;
      endcase
      push(o, rb(), r3(), z, rb());
      if (op == I_BEQ) continue;
      if (op == I_LW || op == I_SW) begin
        o = blank(ST_MEM);
        o.mem_req = 1'b1; o.iord = 1'b1; o.alu_src = 1'b1;
        if (op == I_LW) o.mem_read = 1'b1;
        else o.mem_write = 1'b1;
        push_access(o, o, flt);
        if (flt) return;
        if (op == I_SW) continue;
      end
      o = blank(ST_WB);
      o.reg_write = 1'b1;
      o.mem_to_reg = (op == I_LW);
      r = ($urandom_range(0, 3) != 0);
      push(o, r, r3(), rb(), rb());
      if (!r) push_idle($urandom_range(0, 2));
    end
    // Leave the sequencer stalled mid-fetch so the next reset lands during an access.
    o = blank(ST_FETCH);
    o.mem_req = 1'b1; o.mem_read = 1'b1;
    push(o, rb(), r3(), rb(), 1'b0);
    push(o, rb(), r3(), rb(), 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    run = 1'b0; opcode = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    check_vec("reset_async", {14'b0, got}, 32'h0);
    @(negedge clock);
    #1;
    check_vec("reset_held", {14'b0, got}, 32'h0);
`ifdef MULTICYCLE_STATS_EN
    check_vec("reset_icnt", {16'b0, instr_count}, 32'h0);
    check_vec("reset_ccnt", {16'b0, cycle_count}, 32'h0);
`endif
    reset_n = 1'b1;
  endtask

  task automatic play(input int ep);
    int exp_instr;
    int exp_cycles;
    exp_instr = 0;
    exp_cycles = 0;
    foreach (q[k]) begin
      @(negedge clock);
      run = q[k].run; opcode = q[k].op; zero = q[k].zero; mem_ready = q[k].rdy;
      #1;
      check_vec($sformatf("ep%0d step%0d st%0d", ep, k, q[k].exp.st), {14'b0, got},
                {14'b0, q[k].exp});
`ifdef MULTICYCLE_STATS_EN
      check_vec($sformatf("ep%0d step%0d icnt", ep, k), {16'b0, instr_count}, 32'(exp_instr));
      check_vec($sformatf("ep%0d step%0d ccnt", ep, k), {16'b0, cycle_count}, 32'(exp_cycles));
`endif
      if (q[k].exp.st == ST_FETCH && q[k].rdy) exp_instr++;
      if (!(q[k].exp.st inside {ST_IDLE, ST_HALT, ST_FAULT})) exp_cycles++;
    end
  endtask

  initial begin
    for (int ep = 0; ep < 40; ep++) begin
      if (ep == 0) force_wait = TMO + 1;
      if (ep == 1) force_wait = TMO;
      apply_reset();
      gen_episode();
      play(ep);
    end
    apply_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
